// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forwarding sequencer for the 5-stage RV32I pipeline.
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_is_load,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic             mem_redirect,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_clr,
    output logic             id_ex_clr,
    output logic             ex_mem_clr,
    output logic             mem_wb_clr,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TO_V = WW'(MEM_TIMEOUT);
    state_t state;
    logic [WW-1:0] wcnt, wcnt_nx;
    logic frozen, halt, active, redirect, load_use;
    function automatic logic [1:0] fsel(input logic [4:0] rs);
        return (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs) ? 2'b10 :
               (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) ? 2'b01 : 2'b00;
    endfunction
    assign wcnt_nx  = wcnt + WW'(1);
    assign halt     = state == HALT;
    assign frozen   = (state == RUN && dmem_req && !dmem_ready) || (state == MEM_WAIT && !dmem_ready);
    assign active   = !halt && !frozen;
    assign redirect = active && mem_redirect;
    assign load_use = active && !mem_redirect && ex_is_load && ex_reg_write && ex_rd != 5'd0 &&
                      ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    assign pc_en      = rst && active && !load_use;
    assign if_id_en   = rst && active && !load_use;
    assign id_ex_en   = rst && active;
    assign ex_mem_en  = rst && active;
    assign mem_wb_en  = rst && active;
    assign if_id_clr  = !rst || redirect;
    assign id_ex_clr  = !rst || redirect || load_use;
    assign ex_mem_clr = !rst || redirect;
    assign mem_wb_clr = !rst || frozen;
    assign fwd_a      = rst ? fsel(ex_rs1) : 2'b00;
    assign fwd_b      = rst ? fsel(ex_rs2) : 2'b00;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            wcnt         <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_en && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
            if (redirect && flush_events != '1) flush_events <= flush_events + CNT_W'(1);
            if (state == RUN && frozen) begin
                wcnt        <= WW'(1);
                state       <= (MEM_TIMEOUT <= 1) ? HALT : MEM_WAIT;
                mem_timeout <= (MEM_TIMEOUT <= 1);
            end else if (state == MEM_WAIT) begin
                wcnt <= wcnt_nx;
                if (dmem_ready) state <= RUN;
                else if (wcnt_nx == TO_V) begin
                    state       <= HALT;
                    mem_timeout <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks of the hazard controller against a behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int CW = 3, TO = 4, SAT = 7;
    logic clk = 0, rst = 0;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_reg_write, ex_is_load, mem_reg_write, mem_redirect;
    logic wb_reg_write, dmem_req, dmem_ready;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr, mem_timeout;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] stall_cycles, flush_events;
    int n_chk = 0, n_pass = 0, n_fail = 0;
    int mode, wcnt, m_stall, m_flush;
    bit m_to, e_redir;
    logic [4:0] e_en;
    logic [3:0] e_clr;
    logic [1:0] e_fa, e_fb;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_redirect(mem_redirect), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_clr(if_id_clr), .id_ex_clr(id_ex_clr),
        .ex_mem_clr(ex_mem_clr), .mem_wb_clr(mem_wb_clr), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fsel(input logic [4:0] rs);
        if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // mode: 0 = running, 1 = waiting on memory (wcnt wait cycles so far), 2 = halted
    task automatic model_outs();
        bit frz, lu;
        frz = (mode == 0 && dmem_req && !dmem_ready) || (mode == 1 && !dmem_ready);
        lu = ex_is_load && ex_reg_write && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        e_en = 5'b11111; e_clr = 4'b0000; e_redir = 0;
        if (mode == 2) e_en = 5'b00000;
        else if (frz) begin e_en = 5'b00000; e_clr = 4'b0001; end
        else if (mem_redirect) begin e_clr = 4'b1110; e_redir = 1; end
        else if (lu) begin e_en = 5'b00111; e_clr = 4'b0100; end
        e_fa = fsel(ex_rs1);
        e_fb = fsel(ex_rs2);
    endtask

    task automatic model_reset();
        mode = 0; wcnt = 0; m_stall = 0; m_flush = 0; m_to = 0;
    endtask

    task automatic idle();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_reg_write, ex_is_load, mem_reg_write, mem_redirect} = '0;
        {wb_reg_write, dmem_req, dmem_ready} = '0;
    endtask

    // called just after a falling edge with inputs already applied
    task automatic step();
        #1;
        model_outs();
        chk("en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, e_en);
        chk("clr", {if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr}, e_clr);
        chk("fwd_a", fwd_a, e_fa);
        chk("fwd_b", fwd_b, e_fb);
        chk("mem_timeout", mem_timeout, m_to);
        chk("stall_cycles", stall_cycles, m_stall);
        chk("flush_events", flush_events, m_flush);
        @(posedge clk);
        if (!e_en[4]) m_stall = (m_stall + 1 > SAT) ? SAT : m_stall + 1;
        if (e_redir) m_flush = (m_flush + 1 > SAT) ? SAT : m_flush + 1;
        if (mode == 0 && dmem_req && !dmem_ready) begin mode = 1; wcnt = 1; end
        else if (mode == 1) begin
            if (dmem_ready) mode = 0;
            else begin
                wcnt++;
                if (wcnt == TO) begin mode = 2; m_to = 1; end
            end
        end
        @(negedge clk);
    endtask

    // asynchronous reset asserted between edges, checked before any clock edge
    task automatic do_reset(input string tag);
        #3 rst = 0;
        #1;
        chk({tag, "_en"}, {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b00000);
        chk({tag, "_clr"}, {if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr}, 4'b1111);
        chk({tag, "_fwd"}, {fwd_a, fwd_b}, 4'b0000);
        chk({tag, "_cnt"}, {mem_timeout, stall_cycles, flush_events}, '0);
        model_reset();
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        idle();
        model_reset();
        mem_reg_write = 1; mem_rd = 5; ex_rs1 = 5; ex_rs2 = 5;
        #2;
        chk("rst_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b00000);
        chk("rst_clr", {if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr}, 4'b1111);
        chk("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
        chk("rst_cnt", {mem_timeout, stall_cycles, flush_events}, '0);
        @(negedge clk);
        rst = 1;
        // forwarding: MEM beats WB, WB alone, x0 never forwarded
        wb_reg_write = 1; wb_rd = 5;
        #1 chk("fwd_mem", fwd_a, 2'b10);
        step();
        mem_reg_write = 0;
        #1 chk("fwd_wb", fwd_a, 2'b01);
        step();
        mem_reg_write = 1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0;
        #1 chk("fwd_x0", fwd_a, 2'b00);
        step();
        // load-use: exactly one bubble
        idle();
        ex_is_load = 1; ex_reg_write = 1; ex_rd = 7; id_use_rs2 = 1; id_rs2 = 7;
        #1 chk("lu_stall", {pc_en, if_id_en, id_ex_clr}, 3'b001);
        step();
        idle();
        #1 chk("lu_cnt", stall_cycles, 1);
        step();
        // redirect coincident with load-use
        ex_is_load = 1; ex_reg_write = 1; ex_rd = 7; id_use_rs2 = 1; id_rs2 = 7; mem_redirect = 1;
        #1 chk("redir_pc", {pc_en, if_id_clr, id_ex_clr, ex_mem_clr}, 4'b1111);
        step();
        idle();
        #1 chk("redir_cnt", {flush_events, stall_cycles}, {3'd1, 3'd1});
        step();
        // three wait cycles then ready; redirect deferred during the wait
        dmem_req = 1; mem_redirect = 1;
        repeat (3) step();
        dmem_ready = 1;
        #1 chk("wait_done", {pc_en, mem_wb_en, mem_wb_clr, if_id_clr}, 4'b1101);
        step();
        idle();
        step();
        do_reset("rst_mid");
        // timeout into HALT, then stall counter saturation
        dmem_req = 1;
        repeat (TO) step();
        #1 chk("halt_flag", {mem_timeout, pc_en, mem_wb_clr}, 3'b100);
        repeat (10) step();
        #1 chk("stall_sat", stall_cycles, SAT);
        do_reset("rst_halt");
        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd = 5'($urandom_range(0, 3));
            {id_use_rs1, id_use_rs2, ex_reg_write, wb_reg_write, mem_reg_write} = 5'($urandom);
            ex_is_load = ($urandom_range(0, 2) == 0);
            mem_redirect = ($urandom_range(0, 3) == 0);
            dmem_req = ($urandom_range(0, 1) == 0);
            dmem_ready = ($urandom_range(0, 4) != 0);
            step();
            if (mode == 2 && $urandom_range(0, 7) == 0) do_reset("rst_rand");
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
